// File: rtl/alu_issue_stage.sv
// Execute front end: ID/EX register, EX/MEM and WB forwarding, load-use bubble and EX/MEM capture.
// Results land in EX/MEM one edge after entering ID/EX; stall freezes both registers.
module alu_issue_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [3:0]    id_op,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [AW-1:0] id_rd_addr,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          stall,
  input  logic          flush,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] alu_first,
  output logic [DW-1:0] alu_second,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          load_use_stall,
  output logic          exm_valid,
  output logic [DW-1:0] exm_result,
  output logic [DW-1:0] exm_store_data,
  output logic [AW-1:0] exm_rd_addr,
  output logic          exm_reg_write,
  output logic          exm_mem_read,
  output logic          exm_zero
);

  localparam logic [3:0] OP_NOP = 4'b1000;

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic          rs_used;
    logic          rt_used;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;
    logic          reg_write;
    logic          mem_read;
  } idex_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] result;
    logic [DW-1:0] store_data;
    logic [AW-1:0] rd_addr;
    logic          reg_write;
    logic          mem_read;
    logic          zero;
  } exm_t;

  idex_t idex_q, idex_d;
  exm_t  exm_q, exm_d;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // A load's EX/MEM result is an address, not data, so it never forwards from EX/MEM.
  always_comb begin
    fwd_rs = idex_q.rs_val;
    if (idex_q.rs_used && exm_q.valid && exm_q.reg_write && !exm_q.mem_read &&
        exm_q.rd_addr == idex_q.rs_addr)
      fwd_rs = exm_q.result;
    else if (idex_q.rs_used && wb_reg_write && wb_rd_addr == idex_q.rs_addr)
      fwd_rs = wb_data;

    fwd_rt = idex_q.rt_val;
    if (idex_q.rt_used && exm_q.valid && exm_q.reg_write && !exm_q.mem_read &&
        exm_q.rd_addr == idex_q.rt_addr)
      fwd_rt = exm_q.result;
    else if (idex_q.rt_used && wb_reg_write && wb_rd_addr == idex_q.rt_addr)
      fwd_rt = wb_data;
  end

  assign alu_first  = fwd_rs;
  assign alu_second = idex_q.use_imm ? idex_q.imm : fwd_rt;
  assign alu_op     = idex_q.valid ? idex_q.op : OP_NOP;

  assign load_use_stall = id_valid && idex_q.valid && idex_q.mem_read && idex_q.reg_write &&
                          ((id_rs_used && id_rs_addr == idex_q.rd_addr) ||
                           (id_rt_used && id_rt_addr == idex_q.rd_addr));

  always_comb begin
    idex_d    = '0;
    idex_d.op = OP_NOP;
    if (stall) begin
      idex_d = idex_q;
    end else if (id_valid && !flush && !load_use_stall) begin
      idex_d.valid     = 1'b1;
      idex_d.op        = id_op;
      idex_d.rs_val    = id_rs_val;
      idex_d.rt_val    = id_rt_val;
      idex_d.imm       = id_imm;
      idex_d.use_imm   = id_use_imm;
      idex_d.rs_used   = id_rs_used;
      idex_d.rt_used   = id_rt_used;
      idex_d.rs_addr   = id_rs_addr;
      idex_d.rt_addr   = id_rt_addr;
      idex_d.rd_addr   = id_rd_addr;
      idex_d.reg_write = id_reg_write;
      idex_d.mem_read  = id_mem_read;
    end
  end

  always_comb begin
    exm_d = exm_q;
    if (!stall) begin
      exm_d.valid      = idex_q.valid;
      exm_d.result     = alu_result;
      exm_d.store_data = fwd_rt;
      exm_d.rd_addr    = idex_q.rd_addr;
      exm_d.reg_write  = idex_q.valid && idex_q.reg_write;
      exm_d.mem_read   = idex_q.valid && idex_q.mem_read;
      exm_d.zero       = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q    <= '0;
      idex_q.op <= OP_NOP;
      exm_q     <= '0;
    end else begin
      idex_q <= idex_d;
      exm_q  <= exm_d;
    end
  end

  assign exm_valid      = exm_q.valid;
  assign exm_result     = exm_q.result;
  assign exm_store_data = exm_q.store_data;
  assign exm_rd_addr    = exm_q.rd_addr;
  assign exm_reg_write  = exm_q.reg_write;
  assign exm_mem_read   = exm_q.mem_read;
  assign exm_zero       = exm_q.zero;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU closing the loop.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_imm, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
  logic [3:0] id_op, id_rs_addr, id_rt_addr, id_rd_addr;
  logic [15:0] id_rs_val, id_rt_val, id_imm;
  logic stall, flush, wb_reg_write;
  logic [3:0] wb_rd_addr;
  logic [15:0] wb_data;
  logic [15:0] alu_first, alu_second, alu_result;
  logic [3:0] alu_op;
  logic alu_zero, load_use_stall;
  logic exm_valid, exm_reg_write, exm_mem_read, exm_zero;
  logic [15:0] exm_result, exm_store_data;
  logic [3:0] exm_rd_addr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_first + alu_second;
      4'b0001: alu_result = alu_first - alu_second;
      4'b0010: alu_result = alu_first & alu_second;
      4'b0011: alu_result = alu_first | alu_second;
      4'b0100: alu_result = alu_first ^ alu_second;
      4'b1100: alu_result = alu_second;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  alu_issue_stage #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_op(id_op), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .alu_first(alu_first), .alu_second(alu_second), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .load_use_stall(load_use_stall),
    .exm_valid(exm_valid), .exm_result(exm_result), .exm_store_data(exm_store_data),
    .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_zero(exm_zero)
  );

  task automatic idle();
    id_valid = 0; id_op = 4'b1000; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_use_imm = 0; id_rs_used = 0; id_rt_used = 0; id_rs_addr = 0; id_rt_addr = 0;
    id_rd_addr = 0; id_reg_write = 0; id_mem_read = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] rsv, input logic [15:0] rtv,
                       input logic [15:0] imm, input logic use_imm, input logic rs_u,
                       input logic rt_u, input logic [3:0] rsa, input logic [3:0] rta,
                       input logic [3:0] rda, input logic rw, input logic mr);
    id_valid = 1; id_op = op; id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
    id_use_imm = use_imm; id_rs_used = rs_u; id_rt_used = rt_u; id_rs_addr = rsa;
    id_rt_addr = rta; id_rd_addr = rda; id_reg_write = rw; id_mem_read = mr;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); stall = 0; flush = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
    rst = 0;
    #12;
    checks++; if (alu_op !== 4'b1000) begin errors++; $display("FAIL reset_alu_op: got %b expected 1000", alu_op); end
    checks++; if ({exm_valid, exm_result, exm_store_data, exm_rd_addr, exm_reg_write, exm_mem_read, exm_zero} !== '0) begin
      errors++; $display("FAIL reset_exm: got v=%b r=%h sd=%h rd=%h expected all zero", exm_valid, exm_result, exm_store_data, exm_rd_addr); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_lus: got %b expected 0", load_use_stall); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_add();
    tick();
    issue(4'b0000, 16'd5, 16'd7, 16'd0, 0, 1, 1, 4'd1, 4'd2, 4'd3, 1, 0);
    tick(); idle(); #1;
    checks++; if (alu_first !== 16'd5 || alu_second !== 16'd7 || alu_op !== 4'b0000) begin
      errors++; $display("FAIL add_operands: got %h %h op=%b expected 0005 0007 op=0000", alu_first, alu_second, alu_op); end
    tick();
    checks++; if (exm_result !== 16'd12 || exm_zero !== 1'b0 || exm_valid !== 1'b1 || exm_rd_addr !== 4'd3) begin
      errors++; $display("FAIL add_result: got r=%h z=%b v=%b rd=%h expected 000c 0 1 3", exm_result, exm_zero, exm_valid, exm_rd_addr); end
  endtask

  task automatic test_back_to_back();
    issue(4'b0001, 16'd9, 16'd9, 16'd0, 0, 1, 1, 4'd1, 4'd2, 4'd3, 1, 0);
    tick();
    issue(4'b0011, 16'hAAAA, 16'h0000, 16'h00F0, 1, 1, 0, 4'd3, 4'd0, 4'd4, 1, 0);
    tick(); idle(); #1;
    checks++; if (exm_result !== 16'h0000 || exm_zero !== 1'b1) begin
      errors++; $display("FAIL b2b_sub_zero: got r=%h z=%b expected 0000 1", exm_result, exm_zero); end
    checks++; if (alu_first !== 16'h0000 || alu_second !== 16'h00F0) begin
      errors++; $display("FAIL b2b_exm_forward: got %h %h expected 0000 00f0", alu_first, alu_second); end
    tick();
    checks++; if (exm_result !== 16'h00F0 || exm_zero !== 1'b0 || exm_rd_addr !== 4'd4) begin
      errors++; $display("FAIL b2b_or_result: got r=%h z=%b rd=%h expected 00f0 0 4", exm_result, exm_zero, exm_rd_addr); end
  endtask

  task automatic test_forward_priority();
    issue(4'b1100, 16'h0000, 16'h2222, 16'h0000, 0, 0, 0, 4'd0, 4'd0, 4'd5, 1, 0);
    tick();
    issue(4'b0000, 16'h0042, 16'h0000, 16'h0000, 1, 1, 0, 4'd5, 4'd0, 4'd6, 1, 0);
    wb_reg_write = 1; wb_rd_addr = 4'd5; wb_data = 16'h1111;
    tick(); idle(); #1;
    checks++; if (alu_first !== 16'h2222) begin errors++; $display("FAIL fwd_exm_wins: got %h expected 2222", alu_first); end
    tick();
    checks++; if (exm_result !== 16'h2222) begin errors++; $display("FAIL fwd_exm_result: got %h expected 2222", exm_result); end
    // Same pair again, producer now does not write.
    issue(4'b1100, 16'h0000, 16'h2222, 16'h0000, 0, 0, 0, 4'd0, 4'd0, 4'd5, 0, 0);
    tick();
    issue(4'b0000, 16'h0042, 16'h0000, 16'h0000, 1, 1, 0, 4'd5, 4'd0, 4'd6, 1, 0);
    tick(); idle(); #1;
    checks++; if (alu_first !== 16'h1111) begin errors++; $display("FAIL fwd_wb: got %h expected 1111", alu_first); end
    wb_reg_write = 0; #1;
    checks++; if (alu_first !== 16'h0042) begin errors++; $display("FAIL fwd_none: got %h expected 0042", alu_first); end
    tick();
  endtask

  task automatic test_load_use();
    issue(4'b0000, 16'h0100, 16'h0000, 16'h0004, 1, 1, 0, 4'd1, 4'd0, 4'd2, 1, 1);
    tick();
    issue(4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 4'd2, 4'd2, 4'd6, 1, 0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_set: got %b expected 1", load_use_stall); end
    tick();
    checks++; if (load_use_stall !== 1'b0 || alu_op !== 4'b1000) begin
      errors++; $display("FAIL lu_one_cycle: got lus=%b op=%b expected 0 1000", load_use_stall, alu_op); end
    checks++; if (exm_valid !== 1'b1 || exm_mem_read !== 1'b1 || exm_rd_addr !== 4'd2) begin
      errors++; $display("FAIL lu_load_in_exm: got v=%b mr=%b rd=%h expected 1 1 2", exm_valid, exm_mem_read, exm_rd_addr); end
    tick(); idle();
    wb_reg_write = 1; wb_rd_addr = 4'd2; wb_data = 16'hBEEF; #1;
    checks++; if (exm_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got exm_valid=%b expected 0", exm_valid); end
    checks++; if (alu_first !== 16'hBEEF || alu_second !== 16'hBEEF) begin
      errors++; $display("FAIL lu_wb_forward: got %h %h expected beef beef", alu_first, alu_second); end
    tick(); wb_reg_write = 0;
    checks++; if (exm_result !== 16'h7DDE || exm_valid !== 1'b1 || exm_rd_addr !== 4'd6) begin
      errors++; $display("FAIL lu_result: got r=%h v=%b rd=%h expected 7dde 1 6", exm_result, exm_valid, exm_rd_addr); end
  endtask

  task automatic test_stall_flush();
    issue(4'b1100, 16'h0000, 16'h5555, 16'h0000, 0, 0, 0, 4'd0, 4'd0, 4'd9, 1, 0);
    tick();
    issue(4'b0000, 16'd3, 16'd4, 16'd0, 0, 0, 0, 4'd0, 4'd0, 4'd7, 1, 0);
    tick();
    issue(4'b0011, 16'h0010, 16'h0001, 16'd0, 0, 0, 0, 4'd0, 4'd0, 4'd8, 1, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick();
      checks++; if (alu_first !== 16'd3 || alu_second !== 16'd4 || alu_op !== 4'b0000) begin
        errors++; $display("FAIL stall_idex_hold[%0d]: got %h %h op=%b expected 0003 0004 op=0000", i, alu_first, alu_second, alu_op); end
      checks++; if (exm_result !== 16'h5555 || exm_rd_addr !== 4'd9 || exm_valid !== 1'b1) begin
        errors++; $display("FAIL stall_exm_hold[%0d]: got r=%h rd=%h v=%b expected 5555 9 1", i, exm_result, exm_rd_addr, exm_valid); end
    end
    stall = 0; flush = 0;
    tick();
    checks++; if (exm_result !== 16'd7 || exm_rd_addr !== 4'd7) begin
      errors++; $display("FAIL stall_release: got r=%h rd=%h expected 0007 7", exm_result, exm_rd_addr); end
    issue(4'b0100, 16'hFFFF, 16'h0F0F, 16'd0, 0, 0, 0, 4'd0, 4'd0, 4'd10, 1, 0);
    flush = 1;
    tick(); flush = 0; idle(); #1;
    checks++; if (exm_result !== 16'h0011 || alu_op !== 4'b1000) begin
      errors++; $display("FAIL flush_kill: got r=%h op=%b expected 0011 1000", exm_result, alu_op); end
    tick();
    checks++; if (exm_valid !== 1'b0 || exm_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%b rw=%b expected 0 0", exm_valid, exm_reg_write); end
  endtask

  task automatic test_async_reset();
    issue(4'b0000, 16'h0001, 16'h0002, 16'd0, 0, 0, 0, 4'd0, 4'd0, 4'd11, 1, 0);
    tick();
    issue(4'b0001, 16'h0009, 16'h0002, 16'd0, 0, 0, 0, 4'd0, 4'd0, 4'd12, 1, 0);
    tick(); idle();
    #2; rst = 0; #1;
    checks++; if (alu_op !== 4'b1000 || exm_valid !== 1'b0 || exm_result !== 16'h0000 ||
                  exm_rd_addr !== 4'd0 || exm_reg_write !== 1'b0) begin
      errors++; $display("FAIL async_reset: got op=%b v=%b r=%h rd=%h rw=%b expected 1000 0 0000 0 0",
                         alu_op, exm_valid, exm_result, exm_rd_addr, exm_reg_write); end
    @(negedge clk); rst = 1;
    tick();
    issue(4'b0000, 16'h0010, 16'h0020, 16'd0, 0, 0, 0, 4'd0, 4'd0, 4'd1, 1, 0);
    tick(); idle(); tick();
    checks++; if (exm_result !== 16'h0030 || exm_valid !== 1'b1 || exm_rd_addr !== 4'd1) begin
      errors++; $display("FAIL post_reset: got r=%h v=%b rd=%h expected 0030 1 1", exm_result, exm_valid, exm_rd_addr); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_forward_priority();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
